shader_sequencer: RTL and testbench
===================================

SHADER_SEQUENCER -- requirements
Module: shader_sequencer

Interface
REQ-001 Parameter NUM_INSTR, default 16, program length in instructions; power of two, 2..64.
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 load_valid_i  input  1  program byte offered on load_data_i.
REQ-005 load_data_i  input  8  program instruction byte.
REQ-006 load_ready_o  output  1  sequencer accepts a program byte this cycle.
REQ-007 load_restart_i  input  1  return write pointer to entry 0.
REQ-008 start_i  input  1  one-cycle pulse to run the program for one pixel.
REQ-009 instr_o  output  8  instruction to the execute stage, registered.
REQ-010 execute_o  output  1  instr_o valid for execution this cycle, registered.
REQ-011 busy_o  output  1  high while in RUN.
REQ-012 done_o  output  1  one-cycle pulse after the last instruction is issued.
REQ-013 overrun_o  output  1  sticky flag: start_i arrived while busy.

Function
REQ-014 Program memory: NUM_INSTR x 8 bits; write pointer wptr and read pointer rptr, each log2(NUM_INSTR) bits.
REQ-015 States: IDLE, RUN; reset state IDLE.
REQ-016 load_ready_o = (state == IDLE) and not start_i, combinational.
REQ-017 Load handshake: load_valid_i and load_ready_o in the same cycle -> mem[wptr] <= load_data_i, wptr increments, wrapping NUM_INSTR-1 -> 0.
REQ-018 load_restart_i forces wptr to 0 that cycle; a simultaneous accepted byte is written to the old wptr and the pointer still ends at 0.
REQ-019 load_valid_i while load_ready_o is low has no effect; the byte is not consumed.
REQ-020 IDLE with start_i high -> RUN; rptr <= 0.
REQ-021 RUN: each cycle instr_o <= mem[rptr], execute_o <= 1, rptr increments; first execute_o rises the cycle after the start_i edge (latency 1).
REQ-022 Exactly NUM_INSTR consecutive execute_o cycles per start, no gaps, issued in order 0..NUM_INSTR-1.
REQ-023 After issuing entry NUM_INSTR-1 -> IDLE; done_o high for exactly the following cycle, and execute_o low in that cycle.
REQ-024 In IDLE, execute_o = 0 and instr_o holds its last value.
REQ-025 start_i while in RUN is ignored for sequencing and sets overrun_o, which stays set until reset.
REQ-026 start_i in the same cycle as done_o is a valid start; the new run begins next cycle, giving one execute_o-low gap between runs.
REQ-027 busy_o = (state == RUN).

Reset
REQ-028 rst_i high, sampled on a clock edge, sets:
- state = IDLE, wptr = 0, rptr = 0;
- instr_o = 0x00, execute_o = 0, done_o = 0, overrun_o = 0.
REQ-029 Reset mid-run aborts immediately; no done_o is produced for the aborted run.
REQ-030 Program memory contents at reset are governed by REQ-031 and REQ-032.

Configuration
REQ-031 Macro SHADER_SEQ_DEFAULT_PROG_EN defined:
- reset loads a default program: mem[0] = 0x10 (GETX r0), mem[1] = 0x00 (SETRGB r0), all other entries 0x00.
REQ-032 SHADER_SEQ_DEFAULT_PROG_EN undefined:
- reset clears every memory entry to 0x00;
- all other behaviour is identical.

Verification
REQ-033 Load 0x10,0x20,...,0x100 mod 256 (16 bytes) in IDLE, then pulse start_i -> execute_o high for 16 cycles starting 1 cycle after start; instr_o = 0x10,0x20,...,0xF0,0x00; done_o one pulse in the next cycle.
REQ-034 Pulse start_i again 3 cycles into a run -> overrun_o = 1 and stays 1; run length is unchanged at 16 cycles; done_o fires once.
REQ-035 Write 5 bytes, assert load_restart_i, write 0xC5 -> mem[0] = 0xC5 and mem[1..4] keep the earlier bytes; check with a run.
REQ-036 Hold load_valid_i during a run -> load_ready_o = 0 throughout; the byte is written only after the return to IDLE.
REQ-037 With the macro defined, reset then start -> instr_o = 0x10, 0x00, then 0x00 for the remaining entries; without the macro -> all 0x00.
REQ-038 Assert rst_i in cycle 7 of a run -> next cycle execute_o = 0, busy_o = 0, done_o stays 0.

Source files
------------

// File: rtl/shader_sequencer.sv
// rtl/shader_sequencer.sv - program store and in-order instruction issue for one pixel per start
// Optional feature macro: SHADER_SEQ_DEFAULT_PROG_EN (reset preloads GETX r0 / SETRGB r0).
module shader_sequencer #(
  parameter int NUM_INSTR = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_valid_i,
  input  logic [7:0] load_data_i,
  output logic       load_ready_o,
  input  logic       load_restart_i,
  input  logic       start_i,
  output logic [7:0] instr_o,
  output logic       execute_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       overrun_o
);

  localparam int AW = $clog2(NUM_INSTR);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [7:0]    mem_q [NUM_INSTR];
  logic [7:0]    mem_d [NUM_INSTR];
  logic [7:0]    instr_q, instr_d;
  logic          execute_q, execute_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          load_fire;

  assign load_ready_o = (state_q == IDLE) && !start_i;
  assign load_fire    = load_valid_i && load_ready_o;
  assign instr_o      = instr_q;
  assign execute_o    = execute_q;
  assign busy_o       = (state_q == RUN);
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;

  // Next-state: program loading, and issue where rptr names the next entry to send.
  // Entry 0 goes out on the start edge, so rptr wrapping back to 0 in RUN means
  // every entry has been issued and this edge produces the done pulse instead.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;
    instr_d   = instr_q;
    execute_d = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (load_fire) begin
      mem_d[wptr_q] = load_data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (load_restart_i) begin
      wptr_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          instr_d   = mem_q[0];
          execute_d = 1'b1;
          rptr_d    = AW'(1);
        end
      end
      RUN: begin
        if (start_i) begin
          overrun_d = 1'b1;
        end
        if (rptr_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          instr_d   = mem_q[rptr_q];
          execute_d = 1'b1;
          rptr_d    = rptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered outputs and program memory; reset also (re)initialises the program.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      instr_q   <= 8'h00;
      execute_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_INSTR; i++) begin
        mem_q[i] <= 8'h00;
      end
`ifdef SHADER_SEQ_DEFAULT_PROG_EN
      mem_q[0] <= 8'h10;
      mem_q[1] <= 8'h00;
`else
`endif
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      instr_q   <= instr_d;
      execute_q <= execute_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_shader_sequencer.sv
// tb/tb_shader_sequencer.sv - table, directed and randomized checks of shader_sequencer
module tb_shader_sequencer;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_restart = 1'b0;
  logic       start = 1'b0;
  logic       load_ready;
  logic [7:0] instr;
  logic       execute;
  logic       busy;
  logic       done;
  logic       overrun;

  always #5 clk = ~clk;

  shader_sequencer #(.NUM_INSTR(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_valid_i   (load_valid),
    .load_data_i    (load_data),
    .load_ready_o   (load_ready),
    .load_restart_i (load_restart),
    .start_i        (start),
    .instr_o        (instr),
    .execute_o      (execute),
    .busy_o         (busy),
    .done_o         (done),
    .overrun_o      (overrun)
  );

  // Reference model: program array plus a schedule of future per-cycle outputs.
  typedef struct {
    logic       exec;
    logic [7:0] instr;
    logic       done;
  } out_t;

  out_t       sched[$];
  out_t       m_cur;
  logic [7:0] m_mem [N];
  int         m_wptr;
  logic       m_ovr;
  logic       m_known = 1'b0;

  int   n_vec = 0;
  int   n_bad = 0;
  logic ready_pre;

  typedef struct {
    logic       lv;
    logic [7:0] ld;
    logic       lr;
    logic       st;
    logic       e_ready;
    logic       e_exec;
    logic [7:0] e_instr;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    logic idle;
    if (rst) begin
      for (int i = 0; i < N; i++) m_mem[i] = 8'h00;
`ifdef SHADER_SEQ_DEFAULT_PROG_EN
      m_mem[0] = 8'h10;
`endif
      m_wptr  = 0;
      sched.delete();
      m_cur   = '{exec: 1'b0, instr: 8'h00, done: 1'b0};
      m_ovr   = 1'b0;
      m_known = 1'b1;
      return;
    end
    idle = !m_cur.exec;
    if (idle && start) begin
      sched.delete();
      for (int i = 0; i < N; i++) sched.push_back('{exec: 1'b1, instr: m_mem[i], done: 1'b0});
      sched.push_back('{exec: 1'b0, instr: m_mem[N-1], done: 1'b1});
    end else if (!idle && start) begin
      m_ovr = 1'b1;
    end
    if (idle && !start && load_valid) begin
      m_mem[m_wptr] = load_data;
      m_wptr = (m_wptr + 1) % N;
    end
    if (load_restart) m_wptr = 0;
    if (sched.size() > 0) m_cur = sched.pop_front();
    else m_cur = '{exec: 1'b0, instr: m_cur.instr, done: 1'b0};
  endfunction

  // One clock: check the combinational ready, advance the model, compare registered outputs.
  task automatic step();
    #1;
    ready_pre = load_ready;
    if (m_known) chk("load_ready", ready_pre, !m_cur.exec && !start);
    model_edge();
    @(posedge clk);
    #1;
    chk("execute", execute, m_cur.exec);
    chk("instr", instr, m_cur.instr);
    chk("done", done, m_cur.done);
    chk("busy", busy, m_cur.exec);
    chk("overrun", overrun, m_ovr);
  endtask

  function automatic vec_t mk(logic lv, logic [7:0] ld, logic lr, logic st, logic er,
                              logic ee, logic [7:0] ei, logic ed, logic eb);
    vec_t v;
    v = '{lv: lv, ld: ld, lr: lr, st: st, e_ready: er, e_exec: ee, e_instr: ei, e_done: ed, e_busy: eb};
    return v;
  endfunction

  initial begin
    int ne, nd, nlow;
    logic [7:0] def0;

    for (int i = 0; i < 5; i++) tbl[i] = mk(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[6] = mk(1'b1, 8'hC5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[7] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC5, 1'b0, 1'b1);
    for (int k = 1; k < N; k++)
      tbl[7+k] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, (k < 5) ? 8'(8'hA1 + k) : 8'h00, 1'b0, 1'b1);
    tbl[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[24] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_instr", instr, 8'h00);
    chk("rst_execute", execute, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    #1;
    chk("rst_ready", load_ready, 1'b1);

    // Table: five writes, pointer restart, overwrite entry 0, then one full run
    for (int i = 0; i < 25; i++) begin
      load_valid   = tbl[i].lv;
      load_data    = tbl[i].ld;
      load_restart = tbl[i].lr;
      start        = tbl[i].st;
      step();
      chk($sformatf("tbl%0d_ready", i), ready_pre, tbl[i].e_ready);
      chk($sformatf("tbl%0d_exec", i), execute, tbl[i].e_exec);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
    end
    load_valid = 1'b0;
    start = 1'b0;

    // Full 16-byte program 0x10..0x00 and one run
    load_restart = 1'b1;
    step();
    load_restart = 1'b0;
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_data  = 8'((i + 1) * 16);
      step();
    end
    load_valid = 1'b0;
    ne = 0; nd = 0;
    for (int c = 0; c < 19; c++) begin
      start = (c == 0);
      step();
      if (c == 0) chk("prog_first_instr", instr, 8'h10);
      if (c == 15) chk("prog_last_instr", instr, 8'h00);
      ne += int'(execute);
      nd += int'(done);
    end
    chk("prog_exec_count", ne, N);
    chk("prog_done_count", nd, 1);

    // Second start three cycles into a run
    chk("ovr_before", overrun, 1'b0);
    ne = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      start = (c == 0 || c == 3);
      step();
      ne += int'(execute);
      nd += int'(done);
    end
    chk("ovr_exec_count", ne, N);
    chk("ovr_done_count", nd, 1);
    chk("ovr_set", overrun, 1'b1);

    // Byte held during a run is only taken once back in IDLE
    ne = 0; nlow = 0;
    load_data = 8'h5A;
    for (int c = 0; c < 18; c++) begin
      start = (c == 0);
      load_valid = 1'b1;
      step();
      nlow += int'(!ready_pre);
      ne += int'(execute);
    end
    load_valid = 1'b0;
    chk("hold_ready_low", nlow, 17);
    chk("hold_exec_count", ne, N);

    // Back-to-back runs with a start in the done cycle
    ne = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      start = (c == 0 || c == 17);
      step();
      if (c == 0) chk("hold_byte_written", instr, 8'h5A);
      ne += int'(execute);
      nd += int'(done);
    end
    chk("b2b_exec_count", ne, 2 * N);
    chk("b2b_done_count", nd, 2);
    chk("ovr_sticky", overrun, 1'b1);

    // Reset program contents, then reset in cycle 7 of a run
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);
`ifdef SHADER_SEQ_DEFAULT_PROG_EN
    def0 = 8'h10;
`else
    def0 = 8'h00;
`endif
    for (int c = 0; c < 6; c++) begin
      start = (c == 0);
      step();
      if (c == 0) chk("def_instr0", instr, def0);
      if (c == 1) chk("def_instr1", instr, 8'h00);
    end
    start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_exec", execute, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      nd += int'(done);
    end
    chk("abort_no_done", nd, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      start        = ($urandom_range(0, 19) == 0);
      load_valid   = 1'($urandom_range(0, 1));
      load_data    = 8'($urandom);
      load_restart = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
